dcsk_frame_scheduler: RTL and testbench

Sequences transmission of one DCSK frame through the serializer datapath. Per data bit it pulls SPREAD_FACTOR chaos samples from the chaos FIFO, emits them as the reference segment, stores them, then replays them (bit 1) or their negation (bit 0) as the data segment. It sits between the chaos generator FIFO and the modulator output stage. It also owns the per-bit chip counter that tags each emitted chip.

---
 rtl/dcsk_frame_scheduler_if.sv | 33 +++
 rtl/dcsk_frame_scheduler.sv | 132 +++++++++++++
 tb/tb_dcsk_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcsk_frame_scheduler_if.sv
// Signal bundle between the DCSK frame scheduler, its chaos FIFO and the chip output stage.
// The master modport is the scheduler's view; the slave modport is the surrounding logic's view.
interface dcsk_frame_scheduler_if #(
    parameter int SPREAD_FACTOR = 2,
    parameter int FRAME_BITS    = 8,
    parameter int CHIP_W        = 8
);
    localparam int CI_W = $clog2(2 * SPREAD_FACTOR);
    localparam int BI_W = $clog2(FRAME_BITS + 1);

    logic                  start;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  chaos_empty;
    logic [CHIP_W-1:0]     chaos_sample;
    logic                  chaos_rd;
    logic [CHIP_W-1:0]     chip_out;
    logic                  chip_valid;
    logic                  chip_ready;
    logic [CI_W-1:0]       chip_index;
    logic [BI_W-1:0]       bit_index;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, frame_data, chaos_empty, chaos_sample, chip_ready,
        output chaos_rd, chip_out, chip_valid, chip_index, bit_index, busy, done
    );

    modport slave (
        output start, frame_data, chaos_empty, chaos_sample, chip_ready,
        input  chaos_rd, chip_out, chip_valid, chip_index, bit_index, busy, done
    );
endinterface

// File: rtl/dcsk_frame_scheduler.sv
// DCSK frame scheduler: per data bit, emits SPREAD_FACTOR chaos chips as the reference segment,
// then replays them (bit 1) or their saturated negation (bit 0) as the data segment.
module dcsk_frame_scheduler #(
    parameter int SPREAD_FACTOR = 2,
    parameter int FRAME_BITS    = 8,
    parameter int CHIP_W        = 8
) (
    input logic                    clk,
    input logic                    rstn,
    dcsk_frame_scheduler_if.master bus
);
    localparam int CI_W = $clog2(2 * SPREAD_FACTOR);
    localparam int BI_W = $clog2(FRAME_BITS + 1);
    localparam int RB_W = $clog2(SPREAD_FACTOR);

    localparam logic [CHIP_W-1:0] CHIP_MIN = {1'b1, {(CHIP_W-1){1'b0}}};
    localparam logic [CHIP_W-1:0] CHIP_MAX = {1'b0, {(CHIP_W-1){1'b1}}};
    localparam logic [RB_W-1:0]   RB_LAST  = RB_W'(SPREAD_FACTOR - 1);
    localparam logic [BI_W-1:0]   BIT_LAST = BI_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, REF, DATA, DRAIN, DONE} state_t;

    state_t                state;
    logic [FRAME_BITS-1:0] data_sr;   // payload, shifted right so bit 0 is always the current bit
    logic [CI_W-1:0]       chip_cnt;
    logic [BI_W-1:0]       bit_cnt;
    logic [RB_W-1:0]       rb_idx;
    logic [CHIP_W-1:0]     ref_buf [SPREAD_FACTOR];

    logic              slot_free;
    logic              produce_ref;
    logic              produce_data;
    logic [CHIP_W-1:0] ref_chip;
    logic [CHIP_W-1:0] data_chip;

    assign slot_free    = ~bus.chip_valid | bus.chip_ready;
    assign produce_ref  = (state == REF) & slot_free & ~bus.chaos_empty;
    assign produce_data = (state == DATA) & slot_free;

    // The pop must coincide with the load of the FIFO head, so it cannot be registered;
    // gating with rstn keeps the FIFO untouched during the reset cycle.
    assign bus.chaos_rd = rstn & produce_ref;

    assign ref_chip  = ref_buf[rb_idx];
    assign data_chip = data_sr[0]             ? ref_chip :
                       (ref_chip == CHIP_MIN) ? CHIP_MAX : -ref_chip;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let later statements see half-updated state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            data_sr        <= '0;
            chip_cnt       <= '0;
            bit_cnt        <= '0;
            rb_idx         <= '0;
            // NOTE: the reference buffer is small and must read back as zero after reset,
            // so it is cleared here rather than left to infer a RAM.
            for (int i = 0; i < SPREAD_FACTOR; i++) ref_buf[i] <= '0;
            bus.chip_out   <= '0;
            bus.chip_valid <= 1'b0;
            bus.chip_index <= '0;
            bus.bit_index  <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;

            if (produce_ref || produce_data) begin
                bus.chip_valid <= 1'b1;
                bus.chip_index <= chip_cnt;
                bus.bit_index  <= bit_cnt;
            end else if (bus.chip_ready) begin
                bus.chip_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_sr  <= bus.frame_data;
                        chip_cnt <= '0;
                        bit_cnt  <= '0;
                        rb_idx   <= '0;
                        bus.busy <= 1'b1;
                        state    <= REF;
                    end
                end
                REF: begin
                    if (produce_ref) begin
                        bus.chip_out    <= bus.chaos_sample;
                        ref_buf[rb_idx] <= bus.chaos_sample;
                        chip_cnt        <= chip_cnt + 1'b1;
                        if (rb_idx == RB_LAST) begin
                            rb_idx <= '0;
                            state  <= DATA;
                        end else begin
                            rb_idx <= rb_idx + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (produce_data) begin
                        bus.chip_out <= data_chip;
                        if (rb_idx == RB_LAST) begin
                            rb_idx   <= '0;
                            chip_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= DRAIN;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                data_sr <= data_sr >> 1;
                                state   <= REF;
                            end
                        end else begin
                            rb_idx   <= rb_idx + 1'b1;
                            chip_cnt <= chip_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.chip_valid && bus.chip_ready) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcsk_frame_scheduler.sv
// Scoreboard bench for dcsk_frame_scheduler (SF=2, FRAME_BITS=4, CHIP_W=8): directed frames,
// FIFO stall, backpressure, saturation, start-while-busy and mid-frame reset.
module tb_dcsk_frame_scheduler;
    localparam int SF = 2;
    localparam int FB = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    dcsk_frame_scheduler_if #(.SPREAD_FACTOR(SF), .FRAME_BITS(FB), .CHIP_W(CW)) bus ();

    dcsk_frame_scheduler #(.SPREAD_FACTOR(SF), .FRAME_BITS(FB), .CHIP_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] chip;
        logic [1:0] cidx;
        logic [2:0] bidx;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] fifo[$];
    int         smp[8];
    int         expv[16];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pops     = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_hs = -1;
    int last_hs  = -1;
    bit pop_flag = 1'b0;
    bit stall    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        bus.chaos_empty  = stall || (fifo.size() == 0);
        bus.chaos_sample = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_flag) begin
            if (fifo.size() > 0) fifo.delete(0);
            pop_flag = 1'b0;
        end
        drive_fifo();
    endtask

    task automatic load_frame(input int n);
        fifo.delete();
        for (int i = 0; i < 8; i++) fifo.push_back(8'(smp[i]));
        for (int k = 0; k < n; k++)
            exp_q.push_back('{chip: 8'(expv[k]), cidx: 2'(k % 4), bidx: 3'(k / 4)});
        pops     = 0;
        hs_cnt   = 0;
        first_hs = -1;
        last_hs  = -1;
        drive_fifo();
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt, prev + 1);
    endtask

    // Monitor: pops the scoreboard on every chip handshake, tracks pops and done pulses.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (bus.chaos_rd) begin
                check("pop_when_empty", bus.chaos_empty, 0);
                pops++;
                pop_flag = 1'b1;
            end
            if (bus.chip_valid && bus.chip_ready) begin
                check("scoreboard_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("chip", {bus.chip_out, bus.chip_index, bus.bit_index}, mon_e);
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", bus.busy, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int prev;

        // Reset held 3 cycles with start asserted.
        rstn           = 1'b0;
        bus.start      = 1'b1;
        bus.frame_data = 4'hF;
        bus.chip_ready = 1'b1;
        fifo.push_back(8'd55);
        drive_fifo();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {bus.chaos_rd, bus.chip_out, bus.chip_valid, bus.chip_index,
                                    bus.bit_index, bus.busy, bus.done}, 0);
        end
        rstn      = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        check("start_ignored_in_reset", bus.busy, 0);
        check("no_pop_idle", pops, 0);

        // Nominal frame.
        smp  = '{10, 20, 30, 40, 50, 60, 70, 80};
        expv = '{10, 20, 10, 20, 30, 40, -30, -40, 50, 60, 50, 60, 70, 80, -70, -80};
        load_frame(16);
        c = cyc;
        bus.frame_data = 4'b0101;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        wait_done(done_cnt);
        check("first_chip_latency", first_hs - c, 2);
        check("no_bubbles", last_hs - first_hs, 15);
        check("chip_count", hs_cnt, 16);
        check("done_latency", done_cyc - last_hs, 1);
        check("pop_count", pops, 8);
        check("scoreboard_drained", exp_q.size(), 0);

        // Back-to-back start, FIFO stall in REF, empty FIFO in DATA, saturation of -128.
        smp  = '{-128, 3, 11, -12, 25, 127, -1, 64};
        expv = '{-128, 3, 127, -3, 11, -12, -11, 12, 25, 127, 25, 127, -1, 64, -1, 64};
        load_frame(16);
        bus.frame_data = 4'b1100;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        check("back_to_back_start", bus.busy, 1);
        tick();
        stall = 1'b1;
        drive_fifo();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("valid_low_in_stall", bus.chip_valid, 0);
        end
        tick();
        stall = 1'b0;
        drive_fifo();
        tick();
        stall = 1'b1;
        drive_fifo();
        tick();
        check("no_stall_in_data", bus.chip_valid, 1);
        tick();
        check("no_stall_in_data", bus.chip_valid, 1);
        stall = 1'b0;
        drive_fifo();
        wait_done(done_cnt);
        check("pop_count_stall", pops, 8);
        check("scoreboard_drained_stall", exp_q.size(), 0);

        // Backpressure in the first data segment, then start while busy.
        smp  = '{1, 2, 3, 4, 5, 6, 7, 8};
        expv = '{1, 2, -1, -2, 3, 4, 3, 4, 5, 6, -5, -6, 7, 8, 7, 8};
        load_frame(16);
        bus.frame_data = 4'b1010;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.chip_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_hold", {bus.chip_valid, bus.chip_out, bus.chip_index, bus.bit_index, bus.chaos_rd},
                  {1'b1, 8'hFF, 2'd2, 3'd0, 1'b0});
            tick();
        end
        bus.chip_ready = 1'b1;
        tick();
        tick();
        bus.frame_data = 4'b0101;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(done_cnt);
        check("chip_count_bp", hs_cnt, 16);
        check("pop_count_bp", pops, 8);
        check("scoreboard_drained_bp", exp_q.size(), 0);

        // Reset while chip 6 is held.
        smp  = '{1, 2, 3, 4, 5, 6, 7, 8};
        expv = '{1, 2, -1, -2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_frame(6);
        bus.frame_data = 4'b0000;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        rstn           = 1'b0;
        bus.chip_ready = 1'b0;
        #1;
        check("abort_no_pop", bus.chaos_rd, 0);
        prev = done_cnt;
        tick();
        check("abort_outputs", {bus.chaos_rd, bus.chip_out, bus.chip_valid, bus.chip_index,
                                bus.bit_index, bus.busy, bus.done}, 0);
        rstn           = 1'b1;
        bus.chip_ready = 1'b1;
        repeat (5) tick();
        check("abort_no_done", done_cnt, prev);
        check("abort_chips", hs_cnt, 6);
        check("abort_scoreboard", exp_q.size(), 0);

        // Fresh frame after the abort starts from bit 0.
        smp  = '{100, -100, 50, -50, 0, 1, -127, 127};
        expv = '{100, -100, -100, 100, 50, -50, 50, -50, 0, 1, 0, 1, -127, 127, 127, -127};
        load_frame(16);
        bus.frame_data = 4'b0110;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(done_cnt);
        check("chip_count_after_abort", hs_cnt, 16);
        check("pop_count_after_abort", pops, 8);
        check("scoreboard_drained_after_abort", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
